// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: six-digit multiplexed seven-segment driver with dead time, leading-zero blank and blinking colon.
module seven_seg_scanner #(
  parameter logic [31:0] SCAN_DIV     = 32'd50000,
  parameter logic [15:0] BLINK_FRAMES = 16'd100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sec_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] min_tens,
  input  logic [3:0] hour_ones,
  input  logic [3:0] hour_tens,
  input  logic       blank_lz,
  input  logic       colon_en,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };
  logic [31:0] r_pre;
  logic [2:0]  r_idx;
  logic [3:0]  r_sh [6];
  logic        r_ph;
  logic [15:0] r_fc;
  logic        w_start, w_tc, w_fend, w_blank, w_fc_tc;
  logic [3:0]  w_dig;
  assign w_start = r_pre == 32'd0;
  assign w_tc    = r_pre == SCAN_DIV - 32'd1;
  assign w_fend  = w_tc && r_idx == 3'd5;
  assign w_fc_tc = r_fc == BLINK_FRAMES - 16'd1;
  assign w_dig   = r_sh[r_idx];
  // blank_lz is live while the hour_tens digit comes from the frame's shadow
  assign w_blank = blank_lz && r_sh[5] == 4'd0 && r_idx == 3'd5;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre      <= '0;
      r_idx      <= '0;
      r_sh       <= '{default: '0};
      r_ph       <= 1'b0;
      r_fc       <= '0;
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      r_pre <= w_tc ? '0 : r_pre + 32'd1;
      if (w_tc) r_idx <= r_idx == 3'd5 ? '0 : r_idx + 3'd1;
      if (w_start && r_idx == 3'd0)
        r_sh <= '{sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens};
      if (w_fend) begin
        r_fc <= w_fc_tc ? '0 : r_fc + 16'd1;
        if (w_fc_tc) r_ph <= ~r_ph;
      end
      an         <= (w_start || w_blank) ? '1 : ~(6'b1 << r_idx);
      seg        <= SEG_LUT[w_dig];
      dp         <= !(colon_en && r_ph && !w_start && (r_idx == 3'd2 || r_idx == 3'd4));
      frame_done <= w_fend;
    end
  end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed vector checks of the scanner with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seven_seg_scanner;
  logic       clk = 0;
  logic       reset;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens;
  logic       blank_lz, colon_en;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp, frame_done;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  seven_seg_scanner #(.SCAN_DIV(32'd4), .BLINK_FRAMES(16'd2)) dut (
    .clk(clk), .reset(reset),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .hour_ones(hour_ones), .hour_tens(hour_tens),
    .blank_lz(blank_lz), .colon_en(colon_en),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [5:0] an;
    logic [6:0] seg;
    bit         cseg;
    logic       dp;
    logic       fd;
  } vec_t;

  vec_t tbl [12];

  task automatic go(input int k);
    while (cyc < k) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic chk(input string nm, input logic [5:0] ea, input logic [6:0] es, input bit cs,
                     input logic ed, input logic ef);
    checks++;
    if (an !== ea || (cs && seg !== es) || dp !== ed || frame_done !== ef) begin
      errors++;
      $display("FAIL %s cyc=%0d got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h(%0d) dp=%b fd=%b",
               nm, cyc, an, seg, dp, frame_done, ea, es, cs, ed, ef);
    end
  endtask

  initial begin
    tbl[0]  = '{1,  6'h3F, 7'h00, 0, 1, 0};
    tbl[1]  = '{2,  6'h3E, 7'h02, 1, 1, 0};
    tbl[2]  = '{4,  6'h3E, 7'h02, 1, 1, 0};
    tbl[3]  = '{5,  6'h3F, 7'h00, 0, 1, 0};
    tbl[4]  = '{6,  6'h3D, 7'h12, 1, 1, 0};
    tbl[5]  = '{10, 6'h3B, 7'h19, 1, 1, 0};
    tbl[6]  = '{14, 6'h37, 7'h30, 1, 1, 0};
    tbl[7]  = '{18, 6'h2F, 7'h24, 1, 1, 0};
    tbl[8]  = '{21, 6'h3F, 7'h00, 0, 1, 0};
    tbl[9]  = '{22, 6'h1F, 7'h79, 1, 1, 0};
    tbl[10] = '{24, 6'h1F, 7'h79, 1, 1, 1};
    tbl[11] = '{25, 6'h3F, 7'h00, 0, 1, 0};
    reset = 1;
    {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones} = 24'h123456;
    blank_lz = 0;
    colon_en = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 6'h3F, 7'h7F, 1, 1, 0);
    reset = 0;
    for (int i = 0; i < 12; i++) begin
      go(tbl[i].k);
      chk($sformatf("frame0_v%0d", i), tbl[i].an, tbl[i].seg, tbl[i].cseg, tbl[i].dp, tbl[i].fd);
    end
    go(26);
    sec_ones = 4'd7;
    sec_tens = 4'd9;
    go(30);  chk("no_tear_slot1", 6'h3D, 7'h12, 1, 1, 0);
    go(48);  chk("fd_frame1", 6'h1F, 7'h79, 1, 1, 1);
    go(50);  chk("new_sec_ones", 6'h3E, 7'h78, 1, 1, 0);
    go(54);  chk("new_sec_tens", 6'h3D, 7'h10, 1, 1, 0);
    go(57);  chk("dp_dead_slot2", 6'h3F, 7'h00, 0, 1, 0);
    go(58);  chk("dp_on_slot2", 6'h3B, 7'h19, 1, 0, 0);
    go(62);  chk("dp_off_slot3", 6'h37, 7'h30, 1, 1, 0);
    go(66);  chk("dp_on_slot4", 6'h2F, 7'h24, 1, 0, 0);
    go(72);  chk("fd_frame2", 6'h1F, 7'h79, 1, 1, 1);
    go(82);  chk("dp_on_frame3", 6'h3B, 7'h19, 1, 0, 0);
    go(100);
    hour_tens = 4'd0;
    blank_lz = 1;
    go(106); chk("dp_off_frame4", 6'h3B, 7'h19, 1, 1, 0);
    go(122);
    min_tens = 4'hB;
    go(142); chk("lz_blank_a", 6'h3F, 7'h00, 0, 1, 0);
    go(144); chk("lz_blank_b", 6'h3F, 7'h00, 0, 1, 1);
    go(145);
    blank_lz = 0;
    colon_en = 0;
    go(154); chk("colon_off", 6'h3B, 7'h19, 1, 1, 0);
    go(158); chk("code_b_blank", 6'h37, 7'h7F, 1, 1, 0);
    go(166); chk("lz_shown", 6'h1F, 7'h40, 1, 1, 0);
    go(182);
    reset = 1;
    sec_ones = 4'd3;
    go(183); chk("mid_reset", 6'h3F, 7'h7F, 1, 1, 0);
    reset = 0;
    go(184); chk("restart_dead", 6'h3F, 7'h00, 0, 1, 0);
    go(185); chk("restart_reload", 6'h3E, 7'h30, 1, 1, 0);
    for (int k = 186; k < 207; k++) begin
      go(k);
      checks++;
      if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL no_fd_after_reset cyc=%0d got fd=%b want 0", cyc, frame_done);
      end
    end
    go(207); chk("fd_after_restart", 6'h1F, 7'h40, 1, 1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
